// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; tx starts one cycle after a write into an idle, empty FIFO.
// Writes while full are dropped (no backpressure beyond 'full'); define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       R,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       busy,
  output logic       tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif
  state_t        state;

  logic empty, wr_ok, last_tick, pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign busy      = !empty || (state != IDLE);
  assign wr_ok     = wr_en && !full;
  assign last_tick = (cnt == CW'(CLKS_PER_BIT - 1));
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && last_tick));

  // Storage has no reset; pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (R && wr_ok) mem[wptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state   <= IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg <= mem[rptr];
`ifdef UART_TX_PARITY_EN
            par   <= ^mem[rptr];
`endif
            state <= START;
            tx    <= 1'b0;
            cnt   <= '0;
          end
        end
        START: begin
          if (last_tick) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (last_tick) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (last_tick) begin
            cnt   <= '0;
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (last_tick) begin
            cnt <= '0;
            if (pop) begin
              shreg <= mem[rptr];
`ifdef UART_TX_PARITY_EN
              par   <= ^mem[rptr];
`endif
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a serial monitor decodes tx frames.
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic       CLK;
  logic       R;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       busy;
  logic       tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  bit capturing = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .R(R), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .busy(busy), .tx(tx)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge CLK);
    wr_en = 1'b0;
  endtask

  task automatic wait_start(input int n);
    int k = 0;
    while (starts.size() < n && k < 500) begin
      @(negedge CLK);
      k++;
    end
    if (starts.size() < n) check("start_timeout", starts.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy !== 1'b0 || capturing) && k < budget) begin
      @(negedge CLK);
      k++;
    end
    if (busy !== 1'b0 || capturing) check("idle_timeout", busy, 0);
  endtask

  task automatic wait_cyc(input int c);
    int k = 0;
    while (cyc < c && k < 1000) begin
      @(negedge CLK);
      k++;
    end
    if (cyc != c) check("cycle_align", cyc, c);
  endtask

  // Serial monitor: captures a whole frame at negedges, then compares against the scoreboard.
  initial begin
    logic samp [FL];
    logic [7:0] got;
    logic [7:0] e;
    bit aborted;
    bit stable;
    forever begin
      @(negedge CLK);
      if (R === 1'b1 && tx === 1'b0) begin
        capturing = 1;
        aborted = 0;
        starts.push_back(cyc);
        samp[0] = tx;
        for (int i = 1; i < FL; i++) begin
          @(negedge CLK);
          if (R !== 1'b1) begin
            aborted = 1;
            break;
          end
          samp[i] = tx;
        end
        if (!aborted) begin
          stable = 1;
          for (int i = 0; i < FL; i++)
            if (samp[i] !== samp[(i / CPB) * CPB]) stable = 0;
          check("bit_stable", stable, 1);
          check("stop_bit", samp[(NB - 1) * CPB], 1);
          for (int b = 0; b < 8; b++) got[b] = samp[(b + 1) * CPB];
          if (exp_q.size() == 0) begin
            check("unexpected_frame", got, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", got, e);
`ifdef UART_TX_PARITY_EN
            check("parity_bit", samp[9 * CPB], ^e);
`endif
          end
        end
        capturing = 0;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int n0, wr_cyc, s, p, k;
    R = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge CLK);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_full", full, 0);
    R = 1'b1;
    @(negedge CLK);

    // Single byte 0xA5.
    n0 = starts.size();
    wr_cyc = cyc + 1;
    exp_q.push_back(8'hA5);
    wr(8'hA5);
    check("pre_start_tx", tx, 1);
    check("busy_after_write", busy, 1);
    wait_start(n0 + 1);
    check("start_latency", starts[n0], wr_cyc + 1);
    k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("busy_fall", cyc, starts[n0] + FL);
    wait_idle(100);

    // Back-to-back burst.
    n0 = starts.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    wr(8'h00);
    wr(8'hFF);
    wr(8'h55);
    wait_idle(400);
    wait_start(n0 + 3);
    check("b2b_gap1", starts[n0 + 1] - starts[n0], FL);
    check("b2b_gap2", starts[n0 + 2] - starts[n0 + 1], FL);

    // Overflow, then a write on the same edge as the STOP-to-START pop.
    n0 = starts.size();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_q.push_back(i[7:0]);
      wr(i[7:0]);
    end
    check("full_after_fill", full, 1);
    wait_start(n0 + 1);
    p = starts[n0] + FL;
    wait_cyc(p - 1);
    check("full_before_pop", full, 1);
    wr(8'h77);
    check("full_clear_after_pop", full, 0);
    exp_q.push_back(8'h88);
    wr(8'h88);
    wait_idle(600);
    check("frame_count", starts.size() - n0, 6);
    wait_start(n0 + 2);
    check("overflow_b2b", starts[n0 + 1], p);

    // Reset during DATA bit 3 of 0x3C with two more bytes queued.
    n0 = starts.size();
    exp_q.push_back(8'h3C);
    wr(8'h3C);
    wr(8'h11);
    wr(8'h22);
    wait_start(n0 + 1);
    s = starts[n0];
    wait_cyc(s + 4 * CPB + 1);
    check("tx_bit3", tx, 1);
    check("full_queue_busy", busy, 1);
    #2;
    R = 1'b0;
    #1;
    check("arst_tx", tx, 1);
    check("arst_busy", busy, 0);
    check("arst_full", full, 0);
    exp_q.delete();
    @(negedge CLK);
    wr_en = 1'b1;
    wr_data = 8'hEE;
    @(negedge CLK);
    wr_en = 1'b0;
    R = 1'b1;
    repeat (60) @(negedge CLK);
    check("no_frame_after_reset", starts.size(), n0 + 1);
    check("idle_after_reset", busy, 0);

    // Write accepted on the first edge after reset release.
    R = 1'b0;
    @(negedge CLK);
    n0 = starts.size();
    R = 1'b1;
    wr_cyc = cyc + 1;
    exp_q.push_back(8'h5A);
    wr(8'h5A);
    check("busy_first_edge", busy, 1);
    wait_start(n0 + 1);
    check("start_after_release", starts[n0], wr_cyc + 1);
    wait_idle(200);

    check("exp_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
